// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register for the RV32I pipeline.
// Handles one outstanding variable-latency imem request at a time.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRData,
  input  logic        IMemRValid,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        FetchBusy
);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_instr;
  logic [31:0] r_pcd;
  logic [31:0] r_pcp4;
  logic        r_valid;

  logic        w_accept;
  logic        w_deliver;
  logic [31:0] w_instr;
  logic [31:0] w_pc_plus4;

  assign w_accept   = !StallF && !StallD && !FlushD;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_instr    = (r_state == S_HOLD) ? r_buf : IMemRData;

  // A redirect always cancels any delivery in the same cycle.
  assign w_deliver = !PCSrcE && w_accept &&
                     (((r_state == S_WAIT) && IMemRValid) ||
                      (r_state == S_HOLD));

  assign IMemReq   = !reset && (r_state == S_ISSUE) && !PCSrcE;
  assign IMemAddr  = r_pc;
  assign PCF       = r_pc;
  assign InstrD    = r_instr;
  assign PCD       = r_pcd;
  assign PCPlus4D  = r_pcp4;
  assign ValidD    = r_valid;
  assign FetchBusy = (r_state == S_ISSUE) ||
                     ((r_state == S_WAIT) && !IMemRValid) ||
                     (r_state == S_DISCARD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_ISSUE;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
    end else begin
      unique case (r_state)
        S_ISSUE: begin
          if (PCSrcE) r_pc <= PCTargetE;
          else        r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (PCSrcE) begin
            r_pc    <= PCTargetE;
            r_state <= IMemRValid ? S_ISSUE : S_DISCARD;
          end else if (IMemRValid) begin
            if (w_accept) begin
              r_pc    <= w_pc_plus4;
              r_state <= S_ISSUE;
            end else begin
              r_buf   <= IMemRData;
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (PCSrcE) begin
            r_pc    <= PCTargetE;
            r_state <= S_ISSUE;
          end else if (w_accept) begin
            r_pc    <= w_pc_plus4;
            r_state <= S_ISSUE;
          end
        end
        S_DISCARD: begin
          if (PCSrcE)     r_pc <= PCTargetE;
          if (IMemRValid) r_state <= S_ISSUE;
        end
        default: r_state <= S_ISSUE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pcd   <= '0;
      r_pcp4  <= '0;
      r_valid <= 1'b0;
    end else if (FlushD) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (StallD) begin
      r_instr <= r_instr;
    end else if (w_deliver) begin
      r_instr <= w_instr;
      r_pcd   <= r_pc;
      r_pcp4  <= w_pc_plus4;
      r_valid <= 1'b1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable
// instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic [31:0] IMemRData;
  logic        IMemRValid;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusy;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .IMemReq    (IMemReq),
    .IMemAddr   (IMemAddr),
    .IMemRData  (IMemRData),
    .IMemRValid (IMemRValid),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .FetchBusy  (FetchBusy)
  );

  always #5 clk = ~clk;

  int          lat = 1;
  logic        m_pend;
  int          m_cnt;
  logic [31:0] m_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hDEAD_0013;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_addr <= '0;
    end else if (IMemReq) begin
      m_pend <= 1'b1;
      m_cnt  <= lat - 1;
      m_addr <= IMemAddr;
    end else if (m_pend) begin
      if (m_cnt == 0) m_pend <= 1'b0;
      else            m_cnt  <= m_cnt - 1;
    end
  end

  assign IMemRValid = m_pend && (m_cnt == 0);
  assign IMemRData  = IMemRValid ? mem(m_addr) : 32'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 1'b0; PCTargetE = '0;
    tick;
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, 32'h0000_0013);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pcp4", PCPlus4D, 32'h0);
    chk("rst_req", {31'd0, IMemReq}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_busy", {31'd0, FetchBusy}, 32'd1);

    // sequential fetch, latency 1
    for (int k = 0; k < 3; k++) begin
      chk("seq_req", {31'd0, IMemReq}, 32'd1);
      chk("seq_addr", IMemAddr, 32'(4 * k));
      tick;
      chk("seq_bubble", {31'd0, ValidD}, 32'd0);
      chk("seq_wait_busy", {31'd0, FetchBusy}, 32'd0);
      tick;
      chk("seq_valid", {31'd0, ValidD}, 32'd1);
      chk("seq_pcd", PCD, 32'(4 * k));
      chk("seq_instr", InstrD, mem(32'(4 * k)));
      chk("seq_pcp4", PCPlus4D, 32'(4 * k + 4));
      chk("seq_pcf", PCF, 32'(4 * k + 4));
    end

    // response lands under stall -> HOLD
    StallF = 1'b1; StallD = 1'b1;
    tick;
    chk("hold_wait_pcd", PCD, 32'h8);
    tick;
    chk("hold_busy", {31'd0, FetchBusy}, 32'd0);
    chk("hold_req", {31'd0, IMemReq}, 32'd0);
    tick;
    tick;
    chk("hold_pcf", PCF, 32'hC);
    chk("hold_pcd", PCD, 32'h8);
    chk("hold_valid", {31'd0, ValidD}, 32'd1);
    chk("hold_instr", InstrD, mem(32'h8));
    StallF = 1'b0; StallD = 1'b0;
    tick;
    chk("hold_dlv_pcd", PCD, 32'hC);
    chk("hold_dlv_instr", InstrD, mem(32'hC));
    chk("hold_dlv_pcp4", PCPlus4D, 32'h10);
    chk("hold_dlv_pcf", PCF, 32'h10);
    chk("hold_dlv_valid", {31'd0, ValidD}, 32'd1);

    // redirect during WAIT, latency 3 -> DISCARD
    lat = 3;
    tick;
    chk("disc_wait_busy", {31'd0, FetchBusy}, 32'd1);
    PCSrcE = 1'b1; PCTargetE = 32'h100; FlushD = 1'b1;
    tick;
    PCSrcE = 1'b0; FlushD = 1'b0;
    #1;
    chk("disc_pcf", PCF, 32'h100);
    chk("disc_busy", {31'd0, FetchBusy}, 32'd1);
    chk("disc_req", {31'd0, IMemReq}, 32'd0);
    tick;
    chk("disc_rsp_busy", {31'd0, FetchBusy}, 32'd1);
    chk("disc_rsp_valid", {31'd0, ValidD}, 32'd0);
    tick;
    chk("disc_req2", {31'd0, IMemReq}, 32'd1);
    chk("disc_addr2", IMemAddr, 32'h100);
    lat = 1;
    tick;
    tick;
    chk("disc_dlv_pcd", PCD, 32'h100);
    chk("disc_dlv_instr", InstrD, mem(32'h100));
    chk("disc_dlv_pcf", PCF, 32'h104);

    // redirect with response in same cycle
    tick;
    PCSrcE = 1'b1; PCTargetE = 32'h200; FlushD = 1'b1;
    tick;
    PCSrcE = 1'b0; FlushD = 1'b0;
    #1;
    chk("same_req", {31'd0, IMemReq}, 32'd1);
    chk("same_addr", IMemAddr, 32'h200);
    chk("same_valid", {31'd0, ValidD}, 32'd0);
    tick;
    tick;
    chk("same_dlv_pcd", PCD, 32'h200);
    chk("same_dlv_valid", {31'd0, ValidD}, 32'd1);

    // FlushD alone while response arrives
    tick;
    FlushD = 1'b1;
    tick;
    FlushD = 1'b0;
    #1;
    chk("fl_valid", {31'd0, ValidD}, 32'd0);
    chk("fl_instr", InstrD, 32'h0000_0013);
    chk("fl_pcd", PCD, 32'h200);
    chk("fl_pcf", PCF, 32'h204);
    tick;
    chk("fl_dlv_valid", {31'd0, ValidD}, 32'd1);
    chk("fl_dlv_pcd", PCD, 32'h204);
    chk("fl_dlv_instr", InstrD, mem(32'h204));
    chk("fl_dlv_pcf", PCF, 32'h208);

    // wrap at top of address space
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    #1;
    chk("wrap_req_redir", {31'd0, IMemReq}, 32'd0);
    tick;
    PCSrcE = 1'b0;
    #1;
    chk("wrap_pcf", PCF, 32'hFFFF_FFFC);
    chk("wrap_bubble", {31'd0, ValidD}, 32'd0);
    tick;
    tick;
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4D, 32'h0);
    chk("wrap_pcf2", PCF, 32'h0);
    chk("wrap_req", {31'd0, IMemReq}, 32'd1);
    chk("wrap_addr", IMemAddr, 32'h0);

    // reset in the middle of a request
    lat = 2;
    tick;
    reset = 1'b1;
    tick;
    chk("mrst_pcf", PCF, 32'h0);
    chk("mrst_valid", {31'd0, ValidD}, 32'd0);
    chk("mrst_instr", InstrD, 32'h0000_0013);
    chk("mrst_pcd", PCD, 32'h0);
    reset = 1'b0;
    #1;
    chk("mrst_req", {31'd0, IMemReq}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
